uart_alu_engine: RTL
====================

# uart_alu_engine

Parametrised byte-stream command engine that sits directly behind the UART receiver. It frames an opcode plus two multi-byte operands from the `rx_data`/`rx_ready` byte strobe and executes the operation. It drives a registered result, an overflow flag and a one-cycle valid pulse. It generalises the fixed 8-bit operand/operation path with:
- configurable operand width;
- more operations;
- explicit opcode and inter-byte-timeout error reporting.

## Interface
- `DATA_W`, 8, operand/result width in bits; multiple of 8, range 8..32; `NB = DATA_W/8` bytes per operand
- `TIMEOUT_CYC`, 1000, maximum clk cycles between bytes inside a frame; 0 disables the timeout
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rx_ready`  in  1  one-cycle strobe, `rx_data` valid in that cycle
- `rx_data`  in  8  received byte
- `result_data`  out  DATA_W  registered result, held until next valid result
- `overflow`  out  1  registered overflow flag, updated together with `result_data`
- `result_valid`  out  1  one-cycle pulse when `result_data`/`overflow` are updated
- `error`  out  1  one-cycle pulse on frame abort
- `err_code`  out  2  01 = bad opcode, 10 = timeout; held until next `error`
- `busy`  out  1  high whenever state != IDLE

## Operation
- Frame format: opcode byte, then NB bytes of A (MSB first), then NB bytes of B (MSB first).
- States and transitions:
  - IDLE: on `rx_ready`, a valid opcode is latched and the FSM goes to GET_A. An invalid opcode pulses `error` with `err_code`=01 and the FSM stays in IDLE.
  - GET_A: NB bytes are shifted into A; `byte_cnt` counts 0..NB-1, then the FSM goes to GET_B.
  - GET_B: NB bytes are shifted into B; after the last byte the FSM goes to EXEC.
  - EXEC: one cycle. The result is computed and registered, `result_valid` pulses, and the FSM returns to IDLE.
  - A `rx_ready` arriving during EXEC is decoded as the next frame's opcode, with the same rules as IDLE.
- Opcodes; A and B are DATA_W bits, and overflow is 0 unless stated:
  - 0x00 ADD: A+B; overflow = signed two's-complement overflow.
  - 0x01 SUB: A−B; overflow = signed overflow.
  - 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x05 MUL: unsigned, low DATA_W bits of the 2·DATA_W product; overflow = upper half nonzero.
  - 0x06 SHL: A << (B mod DATA_W); overflow = any shifted-out bit was 1.
  - 0x07..0xFF: invalid.
- Timeout (only when `TIMEOUT_CYC`>0):
  - The counter clears on every accepted byte and on entry to GET_A. It increments every cycle in GET_A/GET_B without `rx_ready`.
  - When it reaches `TIMEOUT_CYC`: `error` pulses, `err_code`=10, partial operands are discarded, and the FSM returns to IDLE.
  - If `rx_ready` arrives in the same cycle the count would reach `TIMEOUT_CYC`, the byte wins and there is no error.
  - No timeout runs in IDLE.
- Errors never modify `result_data`, `overflow` or `result_valid`.

## Timing
- Reset values: state IDLE; `result_data`=0, `overflow`=0, `result_valid`=0, `error`=0, `err_code`=00, `busy`=0; A, B, counters cleared.
- Assertion of `rst` mid-frame aborts immediately, with no `error` pulse.
- Byte capture: `rx_ready` high in cycle t → byte registered at the end of t.
- Latency: last B byte strobed in cycle t → EXEC in cycle t+1 → `result_valid`=1 and new `result_data`/`overflow` visible in cycle t+2 for exactly one cycle.
- Opcode error: invalid opcode strobed in cycle t → `error` high in cycle t+1 for one cycle, `err_code` updated in the same cycle.
- `busy` rises the cycle after a valid opcode is strobed. It falls the cycle after EXEC, or after the timeout abort.
- Back-to-back frames with `rx_ready` on consecutive cycles are fully supported, with no dead cycle.

## Test plan
- DATA_W=8 ADD: bytes 0x00,0x7F,0x01 → `result_data`=0x80, `overflow`=1, `result_valid` pulse exactly 2 cycles after the last strobe.
- DATA_W=8 SUB then XOR, back-to-back with no gap: 0x01,0x05,0x07 → 0xFE, ov=0. Then 0x04,0xF0,0x3C → 0xCC, ov=0. Expect two valid pulses and `busy` behaviour as specified.
- DATA_W=16 MUL and SHL:
  - 0x05,0x01,0x00,0x01,0x00 → 0x0000, ov=1.
  - 0x06,0x40,0x01,0x00,0x02 → 0x0004, ov=1.
  - 0x05,0x00,0x03,0x00,0x04 → 0x000C, ov=0.
- Bad opcode: 0x09 → `error` pulse, `err_code`=01, no `result_valid`, `busy` stays 0. A following 0x02,0xF0,0x3C → 0x30.
- Timeout (`TIMEOUT_CYC`=50, DATA_W=16): 0x00,0x12 then idle → `error` after 50 idle cycles, `err_code`=10, `busy`=0, `result_data` unchanged. A byte arriving on the 50th cycle instead is accepted with no error.
- Reset mid-frame: assert `rst` asynchronously after 0x00,0x11 → all outputs return to reset values immediately. The next full frame computes correctly.

Source files
------------

// File: rtl/uart_alu_engine.sv
// Byte-stream command engine behind the UART receiver: frames opcode + two
// MSB-first operands, executes the ALU operation and reports frame errors.
module uart_alu_engine #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] result_data,
    output logic              overflow,
    output logic              result_valid,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              busy
);

    // state  | meaning
    // IDLE   | waiting for an opcode byte
    // GET_A  | shifting in NB bytes of operand A
    // GET_B  | shifting in NB bytes of operand B
    // EXEC   | one cycle: register result, pulse result_valid
    typedef enum logic [1:0] {IDLE, GET_A, GET_B, EXEC} state_t;

    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [BW-1:0]     LAST_BYTE = BW'(NB - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic              TMO_EN    = (TIMEOUT_CYC > 0);
    localparam logic [DATA_W-1:0] DW_L      = DATA_W'(DATA_W);
    localparam int                MSB       = DATA_W - 1;

    state_t              state;
    logic [2:0]          op;
    logic [DATA_W-1:0]   a, b;
    logic [BW-1:0]       byte_cnt;
    logic [TW-1:0]       tmo_cnt;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_ov;
    logic [2*DATA_W-1:0] prod, shl_wide;
    logic [DATA_W-1:0]   sh_amt;
    logic                op_ok;

    assign busy  = (state != IDLE);
    assign op_ok = (rx_data < 8'd7);

    always_comb begin
        alu_res  = '0;
        alu_ov   = 1'b0;
        prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        sh_amt   = b % DW_L;
        shl_wide = {{DATA_W{1'b0}}, a} << sh_amt;
        case (op)
            3'd0: begin
                alu_res = a + b;
                alu_ov  = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            3'd1: begin
                alu_res = a - b;
                alu_ov  = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            3'd2: alu_res = a & b;
            3'd3: alu_res = a | b;
            3'd4: alu_res = a ^ b;
            3'd5: begin
                alu_res = prod[DATA_W-1:0];
                alu_ov  = |prod[2*DATA_W-1:DATA_W];
            end
            3'd6: begin
                alu_res = shl_wide[DATA_W-1:0];
                alu_ov  = |shl_wide[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op           <= '0;
            a            <= '0;
            b            <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            result_data  <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            result_valid <= 1'b0;
            error        <= 1'b0;
            case (state)
                IDLE: ;
                GET_A, GET_B: begin
                    if (rx_ready) begin
                        tmo_cnt <= '0;
                        if (state == GET_A) a <= (a << 8) | DATA_W'(rx_data);
                        else                b <= (b << 8) | DATA_W'(rx_data);
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            state    <= (state == GET_A) ? GET_B : EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
                        // abandon the partial frame; stored result is untouched
                        error    <= 1'b1;
                        err_code <= 2'b10;
                        state    <= IDLE;
                        a        <= '0;
                        b        <= '0;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                    end else if (TMO_EN) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    result_data  <= alu_res;
                    overflow     <= alu_ov;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // opcode decode shared by IDLE and EXEC, so frames can run back-to-back
            if (rx_ready && (state == IDLE || state == EXEC)) begin
                if (op_ok) begin
                    op       <= rx_data[2:0];
                    state    <= GET_A;
                    a        <= '0;
                    b        <= '0;
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                end else begin
                    error    <= 1'b1;
                    err_code <= 2'b01;
                end
            end
        end
    end

endmodule
